// File: rtl/costas_loop_ctrl_if.sv
// Costas loop controller bus: discriminator strobe/error, loop-filter
// handshake, lock threshold, coefficient sets and status outputs.
// The master drives the inputs of the controller; the slave is the controller.
interface costas_loop_ctrl_if #(
    parameter int ERR_WIDTH  = 13,
    parameter int COEF_WIDTH = 32
);
    logic                         iw_Enable_h;
    logic                         iw_Carr_Error_Rdy_h;
    logic signed [ERR_WIDTH-1:0]  iw_Carr_Phase_Error;
    logic                         iw_Loop_Output_Valid;
    logic [ERR_WIDTH-2:0]         iw_Lock_Threshold;
    logic [COEF_WIDTH-1:0]        iw_Wide_C1;
    logic [COEF_WIDTH-1:0]        iw_Wide_C2;
    logic [COEF_WIDTH-1:0]        iw_Narrow_C1;
    logic [COEF_WIDTH-1:0]        iw_Narrow_C2;

    logic                         ow_Carr_Error_Rdy_h;
    logic signed [ERR_WIDTH-1:0]  ow_Carr_Phase_Error;
    logic [COEF_WIDTH-1:0]        ow_PLL_C1;
    logic [COEF_WIDTH-1:0]        ow_PLL_C2;
    logic                         ow_Loop_Filter_ReWork_h;
    logic                         ow_Lock_h;
    logic [2:0]                   ow_State;
    logic [15:0]                  ow_Drop_Cnt;

    modport master (
        output iw_Enable_h, iw_Carr_Error_Rdy_h, iw_Carr_Phase_Error,
               iw_Loop_Output_Valid, iw_Lock_Threshold,
               iw_Wide_C1, iw_Wide_C2, iw_Narrow_C1, iw_Narrow_C2,
        input  ow_Carr_Error_Rdy_h, ow_Carr_Phase_Error, ow_PLL_C1, ow_PLL_C2,
               ow_Loop_Filter_ReWork_h, ow_Lock_h, ow_State, ow_Drop_Cnt
    );

    modport slave (
        input  iw_Enable_h, iw_Carr_Error_Rdy_h, iw_Carr_Phase_Error,
               iw_Loop_Output_Valid, iw_Lock_Threshold,
               iw_Wide_C1, iw_Wide_C2, iw_Narrow_C1, iw_Narrow_C2,
        output ow_Carr_Error_Rdy_h, ow_Carr_Phase_Error, ow_PLL_C1, ow_PLL_C2,
               ow_Loop_Filter_ReWork_h, ow_Lock_h, ow_State, ow_Drop_Cnt
    );
endinterface

// File: rtl/costas_loop_ctrl.sv
// Costas loop lock controller: gates discriminator strobes to the loop
// filter one at a time, scores windows of samples against a lock threshold
// and steps between pull-in, wide tracking and narrow tracking coefficients.
module costas_loop_ctrl #(
    parameter int ERR_WIDTH     = 13,
    parameter int COEF_WIDTH    = 32,
    parameter int LOCK_WIN      = 64,
    parameter int LOCK_PASS     = 56,
    parameter int NARROW_AFTER  = 4,
    parameter int UNLOCK_FAILS  = 2,
    parameter int PULL_TIMEOUT  = 16,
    parameter int REWORK_CYCLES = 4
) (
    input  logic               iw_Clk_p_g,
    input  logic               iw_Rst_n_g,
    costas_loop_ctrl_if.slave  io
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REWORK = 3'd1,
        ST_PULL   = 3'd2,
        ST_WIDE   = 3'd3,
        ST_NARROW = 3'd4
    } state_t;

    localparam int AW = ERR_WIDTH - 1;
    localparam int SW = $clog2(LOCK_WIN + 1);
    localparam int PW = $clog2(NARROW_AFTER + 1);
    localparam int FW = $clog2(UNLOCK_FAILS + 1);
    localparam int TW = $clog2(PULL_TIMEOUT + 1);
    localparam int RW = $clog2(REWORK_CYCLES + 1);

    localparam logic [SW-1:0] WIN_FULL  = SW'(LOCK_WIN);
    localparam logic [SW-1:0] PASS_MIN  = SW'(LOCK_PASS);
    localparam logic [PW-1:0] PASS_LAST = PW'(NARROW_AFTER - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(UNLOCK_FAILS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(PULL_TIMEOUT - 1);
    localparam logic [RW-1:0] RW_LAST   = RW'(REWORK_CYCLES - 1);

    state_t                      state_q;
    logic                        busy_q;
    logic [SW-1:0]               sample_cnt_q;
    logic [SW-1:0]               in_cnt_q;
    logic [PW-1:0]               pass_q;
    logic [FW-1:0]               fail_q;
    logic [TW-1:0]               tmo_q;
    logic [RW-1:0]               rw_cnt_q;
    logic                        lock_q;
    logic                        rework_q;
    logic                        fwd_rdy_q;
    logic signed [ERR_WIDTH-1:0] fwd_err_q;
    logic [COEF_WIDTH-1:0]       c1_q;
    logic [COEF_WIDTH-1:0]       c2_q;
    logic [15:0]                 drop_q;

    logic [AW-1:0] err_low;
    logic          err_neg;
    logic [AW-1:0] abs_err;
    logic          in_thr;
    logic          track;
    logic          busy_eff;
    logic          accept;
    logic          drop;
    logic          win_close;
    logic          win_pass;
    logic          to_rework;

    // Magnitude of the error; the most-negative code saturates to the largest
    // positive magnitude so it still fits in ERR_WIDTH-1 bits.
    assign err_low = io.iw_Carr_Phase_Error[AW-1:0];
    assign err_neg = io.iw_Carr_Phase_Error[ERR_WIDTH-1];
    assign abs_err = !err_neg ? err_low :
                     (err_low == '0) ? {AW{1'b1}} : (~err_low + AW'(1));
    assign in_thr  = (abs_err <= io.iw_Lock_Threshold);

    // A loop-filter completion in the same cycle frees the slot for a new strobe.
    assign track     = (state_q == ST_PULL) || (state_q == ST_WIDE) || (state_q == ST_NARROW);
    assign busy_eff  = busy_q && !io.iw_Loop_Output_Valid;
    assign accept    = track && io.iw_Carr_Error_Rdy_h && !busy_eff;
    assign drop      = track && io.iw_Carr_Error_Rdy_h && busy_eff;
    assign win_close = track && io.iw_Loop_Output_Valid && busy_q && (sample_cnt_q == WIN_FULL);
    assign win_pass  = (in_cnt_q >= PASS_MIN);
    assign to_rework = win_close && !win_pass &&
                       (((state_q == ST_PULL) && (tmo_q == TMO_LAST)) ||
                        ((state_q == ST_WIDE) && (fail_q == FAIL_LAST)));

    assign io.ow_Carr_Error_Rdy_h     = fwd_rdy_q;
    assign io.ow_Carr_Phase_Error     = fwd_err_q;
    assign io.ow_PLL_C1               = c1_q;
    assign io.ow_PLL_C2               = c2_q;
    assign io.ow_Loop_Filter_ReWork_h = rework_q;
    assign io.ow_Lock_h               = lock_q;
    assign io.ow_State                = state_q;
    assign io.ow_Drop_Cnt             = drop_q;

    // Controller FSM: state, sample handshake, window scoring and registered outputs
    always_ff @(posedge iw_Clk_p_g) begin
        if (!iw_Rst_n_g) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            sample_cnt_q <= '0;
            in_cnt_q     <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            tmo_q        <= '0;
            rw_cnt_q     <= '0;
            lock_q       <= 1'b0;
            rework_q     <= 1'b0;
            fwd_rdy_q    <= 1'b0;
            fwd_err_q    <= '0;
            c1_q         <= '0;
            c2_q         <= '0;
            drop_q       <= '0;
        end else begin
            fwd_rdy_q <= 1'b0;
            c1_q      <= (state_q == ST_NARROW) ? io.iw_Narrow_C1 : io.iw_Wide_C1;
            c2_q      <= (state_q == ST_NARROW) ? io.iw_Narrow_C2 : io.iw_Wide_C2;
            if (!io.iw_Enable_h) begin
                state_q      <= ST_IDLE;
                busy_q       <= 1'b0;
                sample_cnt_q <= '0;
                in_cnt_q     <= '0;
                pass_q       <= '0;
                fail_q       <= '0;
                tmo_q        <= '0;
                rw_cnt_q     <= '0;
                lock_q       <= 1'b0;
                rework_q     <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                state_q  <= ST_REWORK;
                rework_q <= 1'b1;
                rw_cnt_q <= '0;
            end else if (state_q == ST_REWORK) begin
                busy_q       <= 1'b0;
                sample_cnt_q <= '0;
                in_cnt_q     <= '0;
                pass_q       <= '0;
                fail_q       <= '0;
                tmo_q        <= '0;
                lock_q       <= 1'b0;
                if (rw_cnt_q == RW_LAST) begin
                    state_q  <= ST_PULL;
                    rework_q <= 1'b0;
                end else begin
                    rw_cnt_q <= rw_cnt_q + RW'(1);
                end
            end else if (!track) begin
                state_q <= ST_IDLE;
            end else if (to_rework) begin
                state_q      <= ST_REWORK;
                rework_q     <= 1'b1;
                rw_cnt_q     <= '0;
                lock_q       <= 1'b0;
                busy_q       <= 1'b0;
                sample_cnt_q <= '0;
                in_cnt_q     <= '0;
                pass_q       <= '0;
                fail_q       <= '0;
                tmo_q        <= '0;
            end else begin
                if (accept) begin
                    busy_q    <= 1'b1;
                    fwd_rdy_q <= 1'b1;
                    fwd_err_q <= io.iw_Carr_Phase_Error;
                end else if (io.iw_Loop_Output_Valid) begin
                    busy_q <= 1'b0;
                end
                if (drop && (drop_q != 16'hFFFF)) begin
                    drop_q <= drop_q + 16'd1;
                end
                if (win_close) begin
                    sample_cnt_q <= accept ? SW'(1) : '0;
                    in_cnt_q     <= (accept && in_thr) ? SW'(1) : '0;
                    case (state_q)
                        ST_PULL: begin
                            if (win_pass) begin
                                state_q <= ST_WIDE;
                                lock_q  <= 1'b1;
                                pass_q  <= '0;
                                fail_q  <= '0;
                                tmo_q   <= '0;
                            end else begin
                                tmo_q <= tmo_q + TW'(1);
                            end
                        end
                        ST_WIDE: begin
                            if (win_pass) begin
                                fail_q <= '0;
                                if (pass_q == PASS_LAST) begin
                                    state_q <= ST_NARROW;
                                    pass_q  <= '0;
                                end else begin
                                    pass_q <= pass_q + PW'(1);
                                end
                            end else begin
                                pass_q <= '0;
                                fail_q <= fail_q + FW'(1);
                            end
                        end
                        default: begin
                            if (!win_pass) begin
                                state_q <= ST_WIDE;
                                pass_q  <= '0;
                                fail_q  <= '0;
                            end
                        end
                    endcase
                end else if (accept) begin
                    sample_cnt_q <= sample_cnt_q + SW'(1);
                    if (in_thr) begin
                        in_cnt_q <= in_cnt_q + SW'(1);
                    end
                end
            end
        end
    end
endmodule
